// File: rtl/tm_pkg.sv
// Shared definitions for the tape SPI target: opcodes, field widths and FSM state encoding.
package tm_pkg;

    localparam int unsigned TM_OP_BITS   = 8;
    localparam int unsigned TM_ADDR_BITS = 16;
    localparam int unsigned TM_DATA_BITS = 8;

    localparam logic [TM_OP_BITS-1:0] TM_SPI_OP_READ  = 8'h03;
    localparam logic [TM_OP_BITS-1:0] TM_SPI_OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRd,
        StWr,
        StIgnore,
        StDone
    } tm_tgt_state_t;

endpackage

// File: rtl/tm_sync_edge.sv
// N-stage synchronizer for an asynchronous input, with single-cycle rise/fall pulses
// derived from the synchronized value.
module tm_sync_edge #(
    parameter int unsigned Stages   = 2,
    parameter bit          ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {Stages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= (sync_q << 1) | Stages'(d_i);
            prev_q <= sync_q[Stages-1];
        end
    end

    assign q_o    = sync_q[Stages-1];
    assign rise_o = sync_q[Stages-1] & ~prev_q;
    assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/tm_tape_spi_target.sv
// SPI mode-0 SRAM responder (READ 0x03 / WRITE 0x02, 16-bit address) with a host side-port.
// Define TM_TAPE_TARGET_SEQ_EN for sequential (auto-increment) data phases.
module tm_tape_spi_target
    import tm_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_sck,
    input  logic                 spi_cs,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic                 host_we_i,
    input  logic [ADDR_BITS-1:0] host_addr_i,
    input  logic [7:0]           host_wdata_i,
    output logic [7:0]           host_rdata_o,
    output logic                 busy_o,
    output logic                 err_o
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    tm_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_sck),
        .q_o    (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // CS resets to its idle (high) level so busy_o is clear out of reset.
    tm_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_cs),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    tm_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_mosi),
        .q_o    (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    logic [7:0] mem [2**ADDR_BITS];

    tm_tgt_state_t            state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [TM_OP_BITS-1:0]    cmd_q, cmd_d;
    logic [TM_ADDR_BITS-1:0]  addr_q, addr_d;
    logic [6:0]               rx_q, rx_d;
    logic [TM_DATA_BITS-1:0]  tx_q, tx_d;
    logic                     miso_q, miso_d;
    logic                     err_q, err_d;
    logic                     ld_q, ld_d;
    logic                     mem_we;
    logic [7:0]               spi_wdata;
    logic [7:0]               spi_rdata;

    assign spi_wdata = {rx_q, mosi_s};
    assign spi_rdata = mem[addr_q[ADDR_BITS-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        err_d   = err_q;
        ld_d    = ld_q;
        mem_we  = 1'b0;

        if (state_q != StIdle && cs_s) begin
            // Abort: any partial byte is simply dropped with the shift registers.
            state_d = StIdle;
            cnt_d   = '0;
            cmd_d   = '0;
            addr_d  = '0;
            rx_d    = '0;
            tx_d    = '0;
            miso_d  = 1'b0;
            ld_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d = StCmd;
                        cnt_d   = '0;
                        miso_d  = 1'b0;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        cmd_d = {cmd_q[6:0], mosi_s};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            if (cmd_d == TM_SPI_OP_READ || cmd_d == TM_SPI_OP_WRITE) begin
                                state_d = StAddr;
                            end else begin
                                state_d = StIgnore;
                                err_d   = 1'b1;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        addr_d = {addr_q[14:0], mosi_s};
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            cnt_d = '0;
                            if (cmd_q == TM_SPI_OP_READ) begin
                                state_d = StRd;
                                ld_d    = 1'b1;
                            end else begin
                                state_d = StWr;
                            end
                        end
                    end
                end
                StRd: begin
                    if (ld_q) begin
                        tx_d = spi_rdata;
                        ld_d = 1'b0;
                    end else if (sck_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
`ifdef TM_TAPE_TARGET_SEQ_EN
                            addr_d = addr_q + 16'd1;
                            ld_d   = 1'b1;
`else
                            state_d = StDone;
                            miso_d  = 1'b0;
`endif
                        end
                    end
                end
                StWr: begin
                    if (sck_rise) begin
                        rx_d  = {rx_q[5:0], mosi_s};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            mem_we = 1'b1;
                            cnt_d  = '0;
                            rx_d   = '0;
`ifdef TM_TAPE_TARGET_SEQ_EN
                            addr_d = addr_q + 16'd1;
`else
                            state_d = StDone;
`endif
                        end
                    end
                end
                StIgnore, StDone: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            miso_q  <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
        end
    end

    // Memory has no reset; the SPI side owns it while CS is asserted.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q[ADDR_BITS-1:0]] <= spi_wdata;
        end else if (host_we_i && !busy_o) begin
            mem[host_addr_i] <= host_wdata_i;
        end
    end

    assign host_rdata_o = mem[host_addr_i];
    assign busy_o       = ~cs_s;
    assign err_o        = err_q;
    assign spi_miso     = miso_q;

    logic unused_sigs;
    assign unused_sigs = ^{sck_s, cs_rise, mosi_rise, mosi_fall, addr_q[15]};

endmodule

// File: tb/tb_tm_tape_spi_target.sv
// Directed bench for tm_tape_spi_target: a table of host/SPI transactions plus hand-written
// sequences for partial writes, bad opcodes, multi-byte reads, busy drops and mid-transfer reset.
module tb_tm_tape_spi_target;
    import tm_pkg::*;

    localparam int unsigned AB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_sck = 1'b0;
    logic          spi_cs = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          host_we = 1'b0;
    logic [AB-1:0] host_addr = '0;
    logic [7:0]    host_wdata = '0;
    logic [7:0]    host_rdata;
    logic          busy;
    logic          err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tm_tape_spi_target #(.ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sck      (spi_sck),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_rdata_o (host_rdata),
        .busy_o       (busy),
        .err_o        (err)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            half();
            spi_sck = 1'b1;
            rx[i] = spi_miso;
            half();
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_start();
        spi_cs = 1'b0;
        half();
    endtask

    task automatic cs_end();
        half();
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic spi_header(input logic [7:0] op, input logic [15:0] addr);
        logic [7:0] d;
        spi_byte(op, d);
        spi_byte(addr[15:8], d);
        spi_byte(addr[7:0], d);
    endtask

    task automatic spi_read(input logic [15:0] addr, output logic [7:0] data);
        cs_start();
        spi_header(TM_SPI_OP_READ, addr);
        spi_byte(8'h00, data);
        cs_end();
    endtask

    task automatic spi_write(input logic [15:0] addr, input logic [7:0] data);
        logic [7:0] d;
        cs_start();
        spi_header(TM_SPI_OP_WRITE, addr);
        spi_byte(data, d);
        cs_end();
    endtask

    task automatic host_write(input logic [AB-1:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_peek(input logic [AB-1:0] a, output logic [7:0] d);
        host_addr = a;
        @(negedge clk);
        d = host_rdata;
    endtask

    localparam int KHostWr = 0;
    localparam int KSpiWr  = 1;
    localparam int KSpiRd  = 2;
    localparam int KHostRd = 3;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] d;
        logic [7:0] b0, b1, b2;

        vecs[0] = '{KHostWr, 16'h0010, 8'h5A, 8'h00};
        vecs[1] = '{KSpiRd,  16'h0010, 8'h00, 8'h5A};
        vecs[2] = '{KSpiWr,  16'h0123, 8'hC3, 8'h00};
        vecs[3] = '{KHostRd, 16'h0023, 8'h00, 8'hC3};
        vecs[4] = '{KSpiRd,  16'h0123, 8'h00, 8'hC3};
        vecs[5] = '{KSpiWr,  16'h00FF, 8'h81, 8'h00};
        vecs[6] = '{KSpiRd,  16'hFFFF, 8'h00, 8'h81};
        vecs[7] = '{KHostRd, 16'h00FF, 8'h00, 8'h81};

        repeat (3) @(negedge clk);
        check("reset miso", 16'(spi_miso), 16'h0);
        check("reset busy", 16'(busy), 16'h0);
        check("reset err", 16'(err), 16'h0);
        check("reset state", 16'(dut.state_q), 16'(StIdle));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle busy", 16'(busy), 16'h0);

        host_write(8'h40, 8'hA5);
        host_peek(8'h40, d);
        check("host wr/rd", 16'(d), 16'h00A5);

        for (int i = 0; i < 8; i++) begin
            case (vecs[i].kind)
                KHostWr: host_write(vecs[i].addr[AB-1:0], vecs[i].data);
                KSpiWr:  spi_write(vecs[i].addr, vecs[i].data);
                KSpiRd: begin
                    spi_read(vecs[i].addr, d);
                    check($sformatf("vec%0d spi read", i), 16'(d), 16'(vecs[i].exp));
                end
                default: begin
                    host_peek(vecs[i].addr[AB-1:0], d);
                    check($sformatf("vec%0d host read", i), 16'(d), 16'(vecs[i].exp));
                end
            endcase
        end
        check("err clean", 16'(err), 16'h0);

        // Partial write: only 5 data bits before CS rises.
        host_write(8'h20, 8'h77);
        cs_start();
        spi_header(TM_SPI_OP_WRITE, 16'h0020);
        spi_bits(8'hFF, 5, d);
        cs_end();
        host_peek(8'h20, d);
        check("partial wr mem", 16'(d), 16'h0077);
        check("partial wr state", 16'(dut.state_q), 16'(StIdle));
        check("partial wr miso", 16'(spi_miso), 16'h0);

        // Unknown opcode.
        cs_start();
        spi_byte(8'h9F, d);
        spi_byte(8'h00, b0);
        spi_byte(8'h00, b1);
        spi_byte(8'h00, b2);
        check("badop err", 16'(err), 16'h1);
        check("badop miso", 16'({b0, b1, b2} != 24'h0), 16'h0);
        cs_end();
        spi_read(16'h0010, d);
        check("after badop read", 16'(d), 16'h005A);
        check("err sticky", 16'(err), 16'h1);

        // Multi-byte read across the address wrap.
        host_write(8'hFE, 8'h11);
        host_write(8'hFF, 8'h22);
        host_write(8'h00, 8'h33);
        cs_start();
        spi_header(TM_SPI_OP_READ, 16'h00FE);
        spi_byte(8'h00, b0);
        spi_byte(8'h00, b1);
        spi_byte(8'h00, b2);
        cs_end();
        check("seq byte0", 16'(b0), 16'h0011);
`ifdef TM_TAPE_TARGET_SEQ_EN
        check("seq byte1", 16'(b1), 16'h0022);
        check("seq byte2", 16'(b2), 16'h0033);
`else
        check("seq byte1", 16'(b1), 16'h0000);
        check("seq byte2", 16'(b2), 16'h0000);
`endif

        // Host write while busy is dropped.
        host_write(8'h50, 8'h12);
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        check("busy high", 16'(busy), 16'h1);
        host_write(8'h50, 8'hEE);
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
        check("busy low", 16'(busy), 16'h0);
        host_peek(8'h50, d);
        check("busy drop", 16'(d), 16'h0012);

        // Reset mid read: 0xA5 at 0x40 puts a 1 on MISO after the first data fall.
        cs_start();
        spi_header(TM_SPI_OP_READ, 16'h0040);
        repeat (4) @(negedge clk);
        check("pre-reset miso", 16'(spi_miso), 16'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst miso", 16'(spi_miso), 16'h0);
        check("rst busy", 16'(busy), 16'h0);
        check("rst state", 16'(dut.state_q), 16'(StIdle));
        check("rst err", 16'(err), 16'h0);
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_read(16'h0040, d);
        check("post-reset read", 16'(d), 16'h00A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
